// File: rtl/truth_table_sweeper.sv
// Sweeps {a,b,c,d} through 0..15 and holds each value HOLD_CYCLES cycles, then samples x into table_out.
// Latency: done pulses 16*HOLD_CYCLES+1 edges after start is accepted. No backpressure; start is ignored unless idle.
// Optional macro SWEEP_MISMATCH_EN adds an exp_table compare (mismatch_vec / mismatch_cnt).
module truth_table_sweeper #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        x,
`ifdef SWEEP_MISMATCH_EN
    input  logic [15:0] exp_table,
    output logic [15:0] mismatch_vec,
    output logic [4:0]  mismatch_cnt,
`endif
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [7:0]  hold_cnt;
    logic        sample;
    logic        accept;

    assign accept = (state == IDLE) && start;
    assign sample = (state == RUN) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (sample && (idx == 4'hF)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stimulus and busy come only from state/index registers, never from inputs.
    assign busy         = (state == RUN);
    assign {a, b, c, d} = (state == RUN) ? idx : 4'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'h0;
            hold_cnt  <= 8'h00;
            table_out <= 16'h0000;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            // Registered from the DONE state, so the pulse lands one edge after the last sample.
            done  <= (state == DONE);
            if (accept) begin
                idx       <= 4'h0;
                hold_cnt  <= 8'h00;
                table_out <= 16'h0000;
            end else if (state == RUN) begin
                if (sample) begin
                    table_out[idx] <= x;
                    hold_cnt       <= 8'h00;
                    idx            <= idx + 4'h1;
                end else begin
                    hold_cnt <= hold_cnt + 8'h01;
                end
            end
        end
    end

`ifdef SWEEP_MISMATCH_EN
    logic miss;
    assign miss = x ^ exp_table[idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_vec <= 16'h0000;
            mismatch_cnt <= 5'd0;
        end else if (accept) begin
            mismatch_vec <= 16'h0000;
            mismatch_cnt <= 5'd0;
        end else if (sample) begin
            mismatch_vec[idx] <= miss;
            mismatch_cnt      <= mismatch_cnt + {4'd0, miss};
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances, vector table plus random tables.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start4, start1;
    logic        x4, x1;
    logic        a4, b4, c4, d4, busy4, done4;
    logic        a1, b1, c1, d1, busy1, done1;
    logic [15:0] table4, table1;
    logic [15:0] exp_tab;
`ifdef SWEEP_MISMATCH_EN
    logic [15:0] mv4, mv1;
    logic [4:0]  mc4, mc1;
`endif

    int          checks = 0;
    int          failures = 0;
    int          mode = 0;
    logic [15:0] rand_tbl = 16'h0000;
    bit          sel1 = 1'b0;

    truth_table_sweeper #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .x(x4),
`ifdef SWEEP_MISMATCH_EN
        .exp_table(exp_tab), .mismatch_vec(mv4), .mismatch_cnt(mc4),
`endif
        .a(a4), .b(b4), .c(c4), .d(d4), .busy(busy4), .done(done4), .table_out(table4)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x(x1),
`ifdef SWEEP_MISMATCH_EN
        .exp_table(exp_tab), .mismatch_vec(mv1), .mismatch_cnt(mc1),
`endif
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .table_out(table1)
    );

    // Circuit under test seen by each instance.
    assign x4 = (mode == 0) ? (a4 & b4) : (mode == 1) ? 1'b1 :
                (mode == 2) ? (a4 ^ b4 ^ c4 ^ d4) : (mode == 3) ? rand_tbl[{a4, b4, c4, d4}] : 1'b0;
    assign x1 = (mode == 0) ? (a1 & b1) : (mode == 1) ? 1'b1 :
                (mode == 2) ? (a1 ^ b1 ^ c1 ^ d1) : (mode == 3) ? rand_tbl[{a1, b1, c1, d1}] : 1'b0;

    logic [3:0]  cur_abcd;
    logic        cur_busy, cur_done;
    logic [15:0] cur_table;
    assign cur_abcd  = sel1 ? {a1, b1, c1, d1} : {a4, b4, c4, d4};
    assign cur_busy  = sel1 ? busy1 : busy4;
    assign cur_done  = sel1 ? done1 : done4;
    assign cur_table = sel1 ? table1 : table4;

    // Reference: the truth table of the selected circuit, computed index by index.
    function automatic logic [15:0] model_table(input int m);
        logic [15:0] t;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            case (m)
                0:       t[i] = v[3] & v[2];
                1:       t[i] = 1'b1;
                2:       t[i] = (v[3] + v[2] + v[1] + v[0]) % 2 == 1;
                3:       t[i] = rand_tbl[i];
                default: t[i] = 1'b0;
            endcase
        end
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_sweep(input bit h1, input int m, input logic [15:0] exp_t,
                             input int restart_idx, input logic [15:0] want);
        int hh;
        hh = h1 ? 1 : 4;
        sel1 = h1;
        mode = m;
        exp_tab = exp_t;
        @(negedge clk);
        if (h1) start1 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        // n = edges since the accept edge
        for (int n = 0; n <= 16 * hh + 2; n++) begin
            if (n < 16 * hh) begin
                check("busy_run", 32'(cur_busy), 32'd1);
                check("abcd_run", 32'(cur_abcd), 32'(n / hh));
            end else begin
                check("busy_end", 32'(cur_busy), 32'd0);
                check("abcd_end", 32'(cur_abcd), 32'd0);
            end
            check("done_timing", 32'(cur_done), 32'(n == 16 * hh + 1));
            if (n == 0) check("table_clear_on_accept", 32'(cur_table), 32'd0);
            if (restart_idx >= 0 && n == restart_idx * hh) begin
                if (h1) start1 = 1'b1; else start4 = 1'b1;
            end else begin
                start1 = 1'b0;
                start4 = 1'b0;
            end
            @(negedge clk);
        end
        check("table_out", 32'(cur_table), 32'(want));
`ifdef SWEEP_MISMATCH_EN
        check("mismatch_vec", 32'(sel1 ? mv1 : mv4), 32'(want ^ exp_t));
        check("mismatch_cnt", 32'(sel1 ? mc1 : mc4), 32'($countones(want ^ exp_t)));
`endif
    endtask

    typedef struct {
        bit          h1;
        int          mode;
        logic [15:0] exp_t;
        int          restart;
        logic [15:0] want;
    } vec_t;

    vec_t vt[7];

    initial begin
        int dcount;
        int bcount;
        vt[0] = '{1'b0, 0, 16'hF001, -1, 16'hF000};
        vt[1] = '{1'b0, 0, 16'hF000, -1, 16'hF000};
        vt[2] = '{1'b1, 1, 16'h0000, -1, 16'hFFFF};
        vt[3] = '{1'b0, 0, 16'h1234,  7, 16'hF000};
        vt[4] = '{1'b0, 2, 16'h6996, -1, 16'h6996};
        vt[5] = '{1'b0, 2, 16'h0000, -1, 16'h6996};
        vt[6] = '{1'b1, 2, 16'hFFFF, -1, 16'h6996};

        rst_n = 1'b0;
        start4 = 1'b1;
        start1 = 1'b1;
        exp_tab = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_abcd4", 32'({a4, b4, c4, d4}), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_table4", 32'(table4), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_table1", 32'(table1), 32'd0);
`ifdef SWEEP_MISMATCH_EN
        check("rst_mv4", 32'(mv4), 32'd0);
        check("rst_mc4", 32'(mc4), 32'd0);
`endif
        start4 = 1'b0;
        start1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy4", 32'(busy4), 32'd0);

        for (int i = 0; i < 7; i++)
            run_sweep(vt[i].h1, vt[i].mode, vt[i].exp_t, vt[i].restart, vt[i].want);

        // Reset while index 5 is on the outputs, with start raised in the reset cycle.
        sel1 = 1'b0;
        mode = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_abcd", 32'({a4, b4, c4, d4}), 32'd5);
        rst_n = 1'b0;
        start4 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start4 = 1'b0;
        check("midrst_abcd", 32'({a4, b4, c4, d4}), 32'd0);
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_done", 32'(done4), 32'd0);
        check("midrst_table", 32'(table4), 32'd0);
        dcount = 0;
        bcount = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            dcount += int'(done4);
            bcount += int'(busy4);
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        check("midrst_no_busy", 32'(bcount), 32'd0);
        run_sweep(1'b0, 0, 16'hF000, -1, 16'hF000);

        for (int r = 0; r < 4; r++) begin
            logic [15:0] et;
            rand_tbl = 16'($urandom);
            et = 16'($urandom);
            run_sweep(1'($urandom_range(0, 1)), 3, et, -1, model_table(3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
